// File: rtl/host_cmd_sequencer.sv
// host_cmd_sequencer
//  Parses host command frames received byte-wise from the UART receiver,
//  issues the decoded command to the SD command engine and returns an
//  ACK/NAK response frame through the UART transmitter.
//
//  Frame in : 0xA5, CMD, [A3 A2 A1 A0 for READ/WRITE], CHK (XOR of CMD+addr)
//  Frame out: ACK = 0xA5, CMD|0x80, status ; NAK = 0xA5, 0xEE
//
//  Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   rx_data/rx_valid  received byte, one-cycle strobe per byte
//   tx_data/tx_start  byte to transmit and its one-cycle launch strobe
//   tx_busy           transmitter busy, rises after tx_start, falls when done
//   sd_req            level request to SD core, held until sd_done/timeout
//   host_cmd/sd_addr  decoded command (1..4) and block address to SD core
//   sd_done/sd_status SD completion strobe and result code
//   busy              high whenever the sequencer is not idle
//   dbg_state         current FSM state, for observation only
module host_cmd_sequencer #(
  parameter int unsigned BYTE_TIMEOUT = 1_000_000,
  parameter int unsigned SD_TIMEOUT   = 4_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        sd_req,
  output logic [3:0]  host_cmd,
  output logic [31:0] sd_addr,
  input  logic        sd_done,
  input  logic [7:0]  sd_status,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_CMD, S_GET_ADDR, S_GET_CHK, S_EXEC,
    S_TX_HDR, S_TX_CODE, S_TX_STAT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d, chk_q, chk_d, code_q, code_d, status_q, status_d;
  logic [31:0] addr_q, addr_d, byte_tmr_q, byte_tmr_d, sd_tmr_q, sd_tmr_d;
  logic [1:0]  cnt_q, cnt_d, tx_phase_q, tx_phase_d;
  logic        nak_q, nak_d, ack_q, ack_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d, sd_req_q, sd_req_d;
  logic [3:0]  host_cmd_q, host_cmd_d;
  logic [31:0] sd_addr_q, sd_addr_d;
  logic [7:0]  tx_byte;
  logic        tx_done, in_get;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      chk_q      <= '0;
      code_q     <= '0;
      status_q   <= '0;
      addr_q     <= '0;
      byte_tmr_q <= '0;
      sd_tmr_q   <= '0;
      cnt_q      <= '0;
      tx_phase_q <= '0;
      nak_q      <= 1'b0;
      ack_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      sd_req_q   <= 1'b0;
      host_cmd_q <= '0;
      sd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      chk_q      <= chk_d;
      code_q     <= code_d;
      status_q   <= status_d;
      addr_q     <= addr_d;
      byte_tmr_q <= byte_tmr_d;
      sd_tmr_q   <= sd_tmr_d;
      cnt_q      <= cnt_d;
      tx_phase_q <= tx_phase_d;
      nak_q      <= nak_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      sd_req_q   <= sd_req_d;
      host_cmd_q <= host_cmd_d;
      sd_addr_q  <= sd_addr_d;
    end
  end

  assign in_get = (state_q == S_GET_CMD) || (state_q == S_GET_ADDR) ||
                  (state_q == S_GET_CHK);

  always_comb begin
    tx_byte = status_q;
    if (state_q == S_TX_HDR)       tx_byte = 8'hA5;
    else if (state_q == S_TX_CODE) tx_byte = code_q;
  end

  // Transmit handshake: a byte is launched with a one-cycle tx_start only
  // while tx_busy is low and not in the cycle right after a launch. The byte
  // counts as sent once tx_busy has been seen high and then low again.
  // tx_phase: 0 = ready to launch, 1 = wait busy high, 2 = wait busy low.
  always_comb begin
    tx_phase_d = tx_phase_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_done    = 1'b0;
    if ((state_q == S_TX_HDR) || (state_q == S_TX_CODE) ||
        (state_q == S_TX_STAT)) begin
      case (tx_phase_q)
        2'd0: if (!tx_busy && !tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_byte;
          tx_phase_d = 2'd1;
        end
        2'd1: if (tx_busy) tx_phase_d = 2'd2;
        default: if (!tx_busy) begin
          tx_phase_d = 2'd0;
          tx_done    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    chk_d      = chk_q;
    code_d     = code_q;
    status_d   = status_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    nak_d      = nak_q;
    ack_d      = ack_q;
    sd_req_d   = sd_req_q;
    host_cmd_d = host_cmd_q;
    sd_addr_d  = sd_addr_q;
    sd_tmr_d   = '0;

    // Inter-byte gap timer; only meaningful while a frame is being received.
    if (rx_valid || !in_get)           byte_tmr_d = '0;
    else if (byte_tmr_q != 32'hFFFF_FFFF) byte_tmr_d = byte_tmr_q + 32'd1;
    else                               byte_tmr_d = byte_tmr_q;

    case (state_q)
      S_IDLE: if (rx_valid && rx_data == 8'hA5) state_d = S_GET_CMD;

      S_GET_CMD: begin
        if (rx_valid) begin
          cmd_d  = rx_data;
          chk_d  = rx_data;
          addr_d = '0;
          nak_d  = 1'b0;
          case (rx_data)
            8'h20, 8'h40: begin
              cnt_d   = 2'd3;
              state_d = S_GET_ADDR;
            end
            8'h10, 8'h50: state_d = S_GET_CHK;
            default: begin
              nak_d   = 1'b1;
              state_d = S_GET_CHK;
            end
          endcase
        end else if (byte_tmr_q >= BYTE_TIMEOUT - 1) begin
          state_d = S_IDLE;
        end
      end

      S_GET_ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_data};
          chk_d  = chk_q ^ rx_data;
          if (cnt_q == 2'd0) state_d = S_GET_CHK;
          else               cnt_d = cnt_q - 2'd1;
        end else if (byte_tmr_q >= BYTE_TIMEOUT - 1) begin
          state_d = S_IDLE;
        end
      end

      S_GET_CHK: begin
        if (rx_valid) begin
          if (rx_data != chk_q || nak_q) begin
            code_d  = 8'hEE;
            ack_d   = 1'b0;
            state_d = S_TX_HDR;
          end else begin
            case (cmd_q)
              8'h10:   host_cmd_d = 4'd1;
              8'h50:   host_cmd_d = 4'd2;
              8'h20:   host_cmd_d = 4'd3;
              default: host_cmd_d = 4'd4;
            endcase
            sd_addr_d = addr_q;   // addr stays 0 for INIT/STATUS
            sd_req_d  = 1'b1;
            state_d   = S_EXEC;
          end
        end else if (byte_tmr_q >= BYTE_TIMEOUT - 1) begin
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        sd_tmr_d = (sd_tmr_q != 32'hFFFF_FFFF) ? sd_tmr_q + 32'd1 : sd_tmr_q;
        // sd_done is checked first so it wins over a coincident timeout.
        if (sd_done) begin
          status_d = sd_status;
          code_d   = cmd_q | 8'h80;
          ack_d    = 1'b1;
        end else if (sd_tmr_q >= SD_TIMEOUT - 1) begin
          status_d = 8'hFF;
          code_d   = 8'hEE;
          ack_d    = 1'b0;
        end
        if (sd_done || sd_tmr_q >= SD_TIMEOUT - 1) begin
          sd_req_d   = 1'b0;
          host_cmd_d = '0;
          sd_addr_d  = '0;
          state_d    = S_TX_HDR;
        end
      end

      S_TX_HDR:  if (tx_done) state_d = S_TX_CODE;
      S_TX_CODE: if (tx_done) state_d = ack_q ? S_TX_STAT : S_IDLE;
      S_TX_STAT: if (tx_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign sd_req    = sd_req_q;
  assign host_cmd  = host_cmd_q;
  assign sd_addr   = sd_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = 4'(state_q);

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Testbench for host_cmd_sequencer: drives host frames, models the UART
// transmitter and SD core, and scores transmitted bytes against a queue.
module tb_host_cmd_sequencer;

  localparam int unsigned BYTE_TO = 40;
  localparam int unsigned SD_TO   = 60;

  logic        clk, reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        sd_req;
  logic [3:0]  host_cmd;
  logic [31:0] sd_addr;
  logic        sd_done;
  logic [7:0]  sd_status;
  logic        busy;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int busy_cnt = 0;

  host_cmd_sequencer #(.BYTE_TIMEOUT(BYTE_TO), .SD_TIMEOUT(SD_TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .sd_req(sd_req), .host_cmd(host_cmd), .sd_addr(sd_addr),
    .sd_done(sd_done), .sd_status(sd_status), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // UART transmitter model + scoreboard on launched bytes
  initial tx_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else if (tx_start) begin
      check("tx_while_busy", {31'b0, tx_busy}, 32'd0);
      if (exp_q.size() == 0) check("tx_unexpected", {24'b0, tx_data}, 32'hFFFF_FFFF);
      else                   check("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
      tx_busy  = 1'b1;
      busy_cnt = $urandom_range(1, 4);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // After the CHK byte: sd_req must be high exactly one cycle later.
  task automatic expect_issue(input string tag, input logic [3:0] cmd,
                              input logic [31:0] addr);
    check({tag, "_req"}, {31'b0, sd_req}, 32'd1);
    check({tag, "_cmd"}, {28'b0, host_cmd}, {28'b0, cmd});
    check({tag, "_addr"}, sd_addr, addr);
  endtask

  task automatic finish_sd(input string tag, input logic [7:0] st);
    sd_status = st;
    sd_done   = 1'b1;
    @(negedge clk);
    sd_done = 1'b0;
    check({tag, "_req_drop"}, {31'b0, sd_req}, 32'd0);
    check({tag, "_cmd_clr"}, {28'b0, host_cmd}, 32'd0);
    @(negedge clk);
    check({tag, "_done2tx"}, {31'b0, tx_start}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !tx_busy) break;
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    rx_data = '0; rx_valid = 1'b0; sd_done = 1'b0; sd_status = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req", {31'b0, sd_req}, 32'd0);
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_cmd", {28'b0, host_cmd}, 32'd0);
    check("rst_addr", sd_addr, 32'd0);
    check("rst_state", {28'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // STATUS, ACK
    exp_q.push_back(8'hA5); exp_q.push_back(8'hD0); exp_q.push_back(8'h00);
    send_byte(8'hA5); send_byte(8'h50);
    check("st_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h50);
    expect_issue("st", 4'd2, 32'd0);
    finish_sd("st", 8'h00);
    wait_idle("st");

    // READ 0x100, with a stray 0xA5 during EXEC that must be discarded
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA0); exp_q.push_back(8'h05);
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h21);
    expect_issue("rd", 4'd3, 32'h0000_0100);
    send_byte(8'hA5);
    check("rd_exec_hold", {31'b0, sd_req}, 32'd1);
    finish_sd("rd", 8'h05);
    wait_idle("rd");

    // sd_done while idle is ignored
    sd_done = 1'b1; @(negedge clk); sd_done = 1'b0; @(negedge clk);
    check("stray_done", {31'b0, busy}, 32'd0);

    // WRITE with bad checksum -> NAK, no SD issue
    exp_q.push_back(8'hA5); exp_q.push_back(8'hEE);
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h56); send_byte(8'h78); send_byte(8'h39);
    check("badchk_req", {31'b0, sd_req}, 32'd0);
    wait_idle("badchk");

    // unknown command -> NAK, then valid INIT
    exp_q.push_back(8'hA5); exp_q.push_back(8'hEE);
    send_byte(8'hA5); send_byte(8'h77); send_byte(8'h77);
    check("unk_req", {31'b0, sd_req}, 32'd0);
    wait_idle("unk");
    exp_q.push_back(8'hA5); exp_q.push_back(8'h90); exp_q.push_back(8'h3C);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h10);
    expect_issue("init", 4'd1, 32'd0);
    finish_sd("init", 8'h3C);
    wait_idle("init");

    // byte timeout mid-frame -> silent drop, then a normal frame
    send_byte(8'hA5); send_byte(8'h20);
    repeat (BYTE_TO / 2) @(negedge clk);
    check("bto_hold", {31'b0, busy}, 32'd1);
    repeat (BYTE_TO) @(negedge clk);
    check("bto_idle", {31'b0, busy}, 32'd0);
    check("bto_req", {31'b0, sd_req}, 32'd0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'hD0); exp_q.push_back(8'h81);
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h50);
    expect_issue("st2", 4'd2, 32'd0);
    finish_sd("st2", 8'h81);
    wait_idle("st2");

    // SD timeout on a READ -> sd_req drops, NAK
    exp_q.push_back(8'hA5); exp_q.push_back(8'hEE);
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h20 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    expect_issue("sdto", 4'd3, 32'hDEAD_BEEF);
    repeat (SD_TO / 2) @(negedge clk);
    check("sdto_hold", {31'b0, sd_req}, 32'd1);
    for (int n = 0; n < int'(SD_TO) + 20; n++) begin
      if (!sd_req) break;
      @(negedge clk);
    end
    check("sdto_drop", {31'b0, sd_req}, 32'd0);
    check("sdto_addr_clr", sd_addr, 32'd0);
    wait_idle("sdto");

    // reset while transmitting the ACK
    exp_q.push_back(8'hA5); exp_q.push_back(8'hC0); exp_q.push_back(8'h11);
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h09); send_byte(8'h49);
    expect_issue("wr", 4'd4, 32'd9);
    finish_sd("wr", 8'h11);
    for (int n = 0; n < 20; n++) begin
      if (tx_busy) break;
      @(negedge clk);
    end
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_tx_start", {31'b0, tx_start}, 32'd0);
    check("mrst_tx_data", {24'b0, tx_data}, 32'd0);
    repeat (6) @(negedge clk);
    check("mrst_no_tx", {31'b0, tx_start}, 32'd0);
    reset = 1'b0;

    // recovery after reset
    exp_q.push_back(8'hA5); exp_q.push_back(8'hD0); exp_q.push_back(8'h42);
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h50);
    expect_issue("rec", 4'd2, 32'd0);
    finish_sd("rec", 8'h42);
    wait_idle("rec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
